// File: rtl/serial_negate_pkg.sv
// rtl/serial_negate_pkg.sv - shared types and constants for the serial two's complement negator
package serial_negate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CARRY_RST = 1'b1;

endpackage

// File: rtl/negate_slice.sv
// rtl/negate_slice.sv - one-bit negate slice: y = ~a ^ cin, cout = ~a & cin
module negate_slice (
  input  logic a,
  input  logic cin,
  output logic y,
  output logic cout
);

  assign y    = ~a ^ cin;
  assign cout = ~a & cin;

endmodule

// File: rtl/serial_negate_ctrl.sv
// rtl/serial_negate_ctrl.sv - bit-serial two's complement sequencer, LSB first, one slice reused WIDTH times
// Optional overflow flag for the most-negative operand is enabled by SERIAL_NEGATE_OVF_EN.
module serial_negate_ctrl
  import serial_negate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
`ifdef SERIAL_NEGATE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             slice_y;
  logic             slice_cout;
  logic [WIDTH-1:0] res_next;
`ifdef SERIAL_NEGATE_OVF_EN
  logic             in_msb;
`endif

  negate_slice u_slice (
    .a    (sr[0]),
    .cin  (carry),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // Result bits enter at the top so that after WIDTH shifts the LSB lands in bit 0.
  assign res_next = {slice_y, res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      sr    <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= CARRY_RST;
`ifdef SERIAL_NEGATE_OVF_EN
      ovf    <= 1'b0;
      in_msb <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sr    <= din;
            carry <= CARRY_RST;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_NEGATE_OVF_EN
            in_msb <= din[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= slice_cout;
          res   <= res_next;
          sr    <= sr >> 1;
          if (cnt == LAST) begin
            // Counter parks at LAST; it is reloaded on the next accept.
            dout  <= res_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
`ifdef SERIAL_NEGATE_OVF_EN
            ovf <= in_msb & res_next[WIDTH-1];
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// tb/tb_serial_negate_ctrl.sv - directed self-checking bench for serial_negate_ctrl (WIDTH=8)
module tb_serial_negate_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
`ifdef SERIAL_NEGATE_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;
  int lat;
  int bcnt;
  int dcnt;

  serial_negate_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
`ifdef SERIAL_NEGATE_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the accepting edge; returns edges until done and busy cycles seen.
  task automatic wait_done(input logic [WIDTH-1:0] held, output int l, output int b);
    l = 0;
    b = 0;
    while (done !== 1'b1 && l < 20) begin
      if (busy === 1'b1) b++;
      if (dout !== held) check("dout_no_partial", dout, held);
      tick;
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] held;
    held  = dout;
    din   = d;
    start = 1'b1;
    tick;
    start = 1'b0;
    din   = $urandom_range(0, 255);
    wait_done(held, lat, bcnt);
    check({tag, "_latency"}, lat, WIDTH);
    check({tag, "_busy_cycles"}, bcnt, WIDTH);
    check({tag, "_dout"}, dout, exp);
    check({tag, "_busy_in_done"}, busy, 0);
    tick;
    check({tag, "_done_pulse_width"}, done, 0);
    check({tag, "_dout_held"}, dout, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
`ifdef SERIAL_NEGATE_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    tick;
    check("idle_busy", busy, 0);

    run_op("neg_82", 8'h82, 8'h7E);
`ifdef SERIAL_NEGATE_OVF_EN
    check("neg_82_ovf", ovf, 0);
`endif
    run_op("neg_00", 8'h00, 8'h00);
`ifdef SERIAL_NEGATE_OVF_EN
    check("neg_00_ovf", ovf, 0);
`endif
    run_op("neg_01", 8'h01, 8'hFF);
`ifdef SERIAL_NEGATE_OVF_EN
    check("neg_01_ovf", ovf, 0);
`endif
    run_op("neg_80", 8'h80, 8'h80);
`ifdef SERIAL_NEGATE_OVF_EN
    check("neg_80_ovf", ovf, 1);
`endif
    run_op("neg_FF", 8'hFF, 8'h01);

    // Second request during RUN must be ignored.
    din   = 8'h05;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    din   = 8'h33;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(8'h01, lat, bcnt);
    check("ignore_latency", lat, WIDTH - 3);
    check("ignore_dout", dout, 8'hFB);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done === 1'b1) dcnt++;
    end
    check("ignore_single_done", dcnt, 0);
    check("ignore_idle_busy", busy, 0);

    // Held start: back-to-back conversions.
    din   = 8'h7F;
    start = 1'b1;
    tick;
    din   = 8'h10;
    wait_done(8'hFB, lat, bcnt);
    check("b2b_first_latency", lat, WIDTH);
    check("b2b_first_dout", dout, 8'h81);
    tick;
    check("b2b_reaccept_busy", busy, 1);
    wait_done(8'h81, lat, bcnt);
    start = 1'b0;
    check("b2b_spacing", lat + 1, WIDTH + 1);
    check("b2b_second_dout", dout, 8'hF0);
    tick;
    tick;
    check("b2b_back_idle", busy, 0);

    // Reset during the fourth RUN cycle.
    din   = 8'h55;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    check("midrun_busy_before", busy, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midrun_busy", busy, 0);
    check("midrun_dout", dout, 0);
    check("midrun_done", done, 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("midrun_no_done", dcnt, 0);
    run_op("after_rst", 8'h02, 8'hFE);

    // Reset wins over start on the same edge.
    rst_n = 1'b0;
    din   = 8'h11;
    start = 1'b1;
    tick;
    check("rst_wins_busy", busy, 0);
    check("rst_wins_dout", dout, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick;
    check("rst_wins_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
